// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared types, iw bit positions and width helpers for the multi-project slot.
package tt_mux_pkg;
  typedef enum logic [1:0] {ST_GUARD, ST_HOLD, ST_RUN} state_t;
  localparam int IW_CLK_BIT = 0;
  localparam int IW_RSTN_BIT = 1;
  function automatic int cnt_w(input int g, input int h);
    return (g > h ? g : h) > 1 ? $clog2(g > h ? g : h) : 1;
  endfunction
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tt_mux_slot_if.sv
// tt_mux_slot_if: project-select handshake plus the resulting active/running status.
interface tt_mux_slot_if import tt_mux_pkg::*; #(
  parameter int N_PROJ = 4
);
  localparam int AW = addr_w(N_PROJ);
  logic sel_valid;
  logic sel_ready;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] active;
  logic running;
  modport master (output sel_valid, sel_addr, input sel_ready, active, running);
  modport slave (input sel_valid, sel_addr, output sel_ready, active, running);
endinterface

// File: rtl/tt_mux_seq.sv
// tt_mux_seq: select handshake and GUARD -> HOLD -> RUN handover sequencer.
// With TT_MUX_OUT_REG_EN defined, running rises one cycle late to match the registered ow.
module tt_mux_seq import tt_mux_pkg::*; #(
  parameter int N_PROJ = 4,
  parameter int GUARD = 2,
  parameter int RST_HOLD = 8
) (
  input logic clk,
  input logic rst_n,
  tt_mux_slot_if.slave sel,
  output state_t state
);
  localparam int AW = addr_w(N_PROJ);
  localparam int CW = cnt_w(GUARD, RST_HOLD);
  localparam state_t START = state_t'(GUARD == 0 ? ST_HOLD : ST_GUARD);
  logic [1:0] sync;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] act, act_nx;
  state_t state_nx;
  logic go, sw, last;
  assign go = sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], 1'b1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= START;
      cnt <= '0;
      act <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      act <= act_nx;
    end
  // Out-of-range selects are accepted (ready stays high) but never switch.
  always_comb begin
    sw = sel.sel_valid && sel.sel_ready && 32'(sel.sel_addr) < N_PROJ;
    last = cnt == CW'(state == ST_GUARD ? GUARD - 1 : RST_HOLD - 1);
    state_nx = !go || sw ? START : state == ST_RUN || !last ? state : state == ST_GUARD ? ST_HOLD : ST_RUN;
    cnt_nx = !go || sw || last || state == ST_RUN ? '0 : cnt + 1'b1;
    act_nx = !go ? '0 : sw ? sel.sel_addr : act;
  end
  assign sel.sel_ready = state == ST_RUN;
  assign sel.active = act;
`ifdef TT_MUX_OUT_REG_EN
  logic run_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run_q <= 1'b0;
    else run_q <= state == ST_RUN;
  assign sel.running = state == ST_RUN && run_q;
`else
  assign sel.running = state == ST_RUN;
`endif
endmodule

// File: rtl/tt_mux_slot.sv
// tt_mux_slot: hosts N_PROJ projects behind one iw/ow bundle with safe runtime switching.
// Optional TT_MUX_OUT_REG_EN registers ow by one flop stage.
module tt_mux_slot import tt_mux_pkg::*; #(
  parameter int N_PROJ = 4,
  parameter int IW_W = 18,
  parameter int OW_W = 24,
  parameter int GUARD = 2,
  parameter int RST_HOLD = 8
) (
  input logic clk,
  input logic rst_n,
  input logic [IW_W-1:0] iw,
  output logic [OW_W-1:0] ow,
  tt_mux_slot_if.slave sel,
  output logic [N_PROJ*IW_W-1:0] proj_iw,
  output logic [N_PROJ-1:0] proj_ena,
  input logic [N_PROJ*OW_W-1:0] proj_ow
);
  if (RST_HOLD < 1) begin : g_chk
    $fatal(1, "tt_mux_slot: RST_HOLD must be at least 1");
  end
  state_t state;
  logic [IW_W-1:0] iw_act;
  logic [OW_W-1:0] ow_mux;
  tt_mux_seq #(.N_PROJ(N_PROJ), .GUARD(GUARD), .RST_HOLD(RST_HOLD)) u_seq (
    .clk(clk),
    .rst_n(rst_n),
    .sel(sel),
    .state(state)
  );
  // Unselected slices stay zero so their clk bit is gated off.
  always_comb begin
    iw_act = iw;
    iw_act[IW_RSTN_BIT] = iw[IW_RSTN_BIT] && state != ST_HOLD;
    ow_mux = proj_ow[sel.active*OW_W +: OW_W];
    proj_iw = '0;
    proj_ena = '0;
    if (state != ST_GUARD) begin
      proj_iw[sel.active*IW_W +: IW_W] = iw_act;
      proj_ena[sel.active] = 1'b1;
    end
  end
`ifdef TT_MUX_OUT_REG_EN
  logic [OW_W-1:0] ow_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ow_q <= '0;
    else ow_q <= state == ST_RUN ? ow_mux : '0;
  assign ow = sel.running ? ow_q : '0;
`else
  assign ow = state == ST_RUN ? ow_mux : '0;
`endif
endmodule

// File: tb/tb_tt_mux_slot.sv
// tb_tt_mux_slot: directed plus random select traffic checked against a timeline model.
// N_PROJ=5 so that sel_addr=7 is a representable out-of-range request.
module tb_tt_mux_slot;
  import tt_mux_pkg::*;
  localparam int N = 5;
  localparam int IW = 18;
  localparam int OW = 24;
  localparam int GUARD = 2;
  localparam int RST_HOLD = 8;
  localparam int LAT = GUARD + RST_HOLD;
`ifdef TT_MUX_OUT_REG_EN
  localparam int RL = LAT + 1;
`else
  localparam int RL = LAT;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [IW-1:0] iw;
  logic [OW-1:0] ow;
  logic [N*IW-1:0] proj_iw;
  logic [N-1:0] proj_ena;
  logic [N*OW-1:0] proj_ow, prev_pow;
  int cyc, m_start, m_act, vecs, errs;
  bit force0;
  logic [OW-1:0] val0;
  tt_mux_slot_if #(.N_PROJ(N)) sel ();
  tt_mux_slot #(.N_PROJ(N), .IW_W(IW), .OW_W(OW), .GUARD(GUARD), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .iw(iw),
    .ow(ow),
    .sel(sel),
    .proj_iw(proj_iw),
    .proj_ena(proj_ena),
    .proj_ow(proj_ow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask
  // k = cycles since the handover began; negative while reset or synchroniser holds it.
  task automatic check_all();
    int k;
    logic [IW-1:0] s;
    logic [N*IW-1:0] e_iw;
    logic [OW-1:0] e_ow;
    k = cyc - m_start;
    s = iw;
    if (k < LAT) s[1] = 1'b0;
    e_iw = '0;
    if (k >= GUARD) e_iw[m_act*IW +: IW] = s;
`ifdef TT_MUX_OUT_REG_EN
    e_ow = k >= RL ? prev_pow[m_act*OW +: OW] : '0;
`else
    e_ow = k >= RL ? proj_ow[m_act*OW +: OW] : '0;
`endif
    chk("ena", 128'(proj_ena), k >= GUARD ? 128'(1) << m_act : 128'(0));
    chk("active", 128'(sel.active), 128'(m_act));
    chk("ready", 128'(sel.sel_ready), 128'(k >= LAT));
    chk("running", 128'(sel.running), 128'(k >= RL));
    chk("proj_iw", 128'(proj_iw), 128'(e_iw));
    chk("ow", 128'(ow), 128'(e_ow));
  endtask
  task automatic step(input bit v, input logic [2:0] a);
    iw = IW'($urandom);
    for (int i = 0; i < N; i++) proj_ow[i*OW +: OW] = OW'($urandom);
    if (force0) proj_ow[OW-1:0] = val0;
    sel.sel_valid = v;
    sel.sel_addr = a;
    #1;
    check_all();
    @(posedge clk);
    if (v && cyc - m_start >= LAT && a < N) begin
      m_act = int'(a);
      m_start = cyc + 1;
    end
    cyc++;
    prev_pow = proj_ow;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0);
  endtask
  initial begin
    iw = '0;
    proj_ow = '0;
    prev_pow = '0;
    sel.sel_valid = 1'b0;
    sel.sel_addr = '0;
    cyc = 0;
    m_act = 0;
    m_start = 1000;
    force0 = 1'b0;
    val0 = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    m_start = cyc + 2;
    idle(LAT + 5);
    step(1'b1, 3'd2);
    for (int i = 0; i < LAT; i++) step(1'b1, 3'($urandom));
    idle(3);
    step(1'b1, 3'd7);
    idle(3);
    step(1'b1, 3'd1);
    idle(LAT + 3);
    step(1'b1, 3'd1);
    idle(LAT + 3);
    step(1'b1, 3'd3);
    idle(GUARD + 3);
    rst_n = 1'b0;
    m_act = 0;
    m_start = cyc + 1000;
    idle(2);
    rst_n = 1'b1;
    m_start = cyc + 2;
    idle(LAT + 4);
    force0 = 1'b1;
    val0 = 24'h000000;
    idle(2);
    val0 = 24'hA5A5A5;
    idle(3);
    force0 = 1'b0;
    for (int i = 0; i < 300; i++) step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
